// File: rtl/seg7_pkg.sv
// Shared constants and the slot-phase type for the 7-segment scan controller.
package seg7_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [MAX_DIGITS-1:0] ANODES_OFF = 8'hFF;
  localparam logic [BCD_W-1:0]      BCD_MAX    = 4'd9;

  // Each digit slot opens with a blanking phase, then drives its anode.
  typedef enum logic {
    PhaseBlank = 1'b0,
    PhaseDrive = 1'b1
  } slot_phase_e;

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: counts 0..DIV-1, tick marks the last cycle of a slot.
module scan_prescaler #(
  parameter int unsigned DIV = 100000,
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] count,
  output logic          tick
);

  assign tick = (count == CW'(DIV - 1));

  // Slot cycle counter, wraps on tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment digit scanner with double-buffered display data.
// Define LEADING_ZERO_BLANK_EN to darken leading zeros above the most
// significant enabled nonzero digit (digit 0 always stays lit).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] digits_in,
  input  logic [7:0]  digit_en,
  input  logic        load,
  output logic        ready,
  output logic [3:0]  bcd_out,
  output logic [7:0]  anodes,
  output logic        frame_done
);

  localparam int unsigned CntW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [2:0]  IdxLast = 3'(NUM_DIGITS - 1);

  logic [CntW-1:0]       count;
  logic                  tick;
  logic                  wrap;
  logic [2:0]            idx_q;

  logic [31:0]           pend_digits_q;
  logic [MAX_DIGITS-1:0] pend_en_q;
  logic                  pend_flag_q;
  logic [31:0]           shad_digits_q;
  logic [MAX_DIGITS-1:0] shad_en_q;

  slot_phase_e           phase;
  logic [BCD_W-1:0]      cur_nib;
  logic                  cur_lit;
  logic [MAX_DIGITS-1:0] anodes_d;

  scan_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .tick  (tick)
  );

  assign wrap  = tick && (idx_q == IdxLast);
  assign ready = ~pend_flag_q;

  // Slot index advances once per slot and wraps at the last scanned digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else if (tick) begin
      idx_q <= (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Pending/shadow double buffer; a wrap transfer and an accepted load are
  // mutually exclusive because one needs the flag set and the other clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_digits_q <= '0;
      pend_en_q     <= '0;
      pend_flag_q   <= 1'b0;
      shad_digits_q <= '0;
      shad_en_q     <= '0;
    end else begin
      if (wrap && pend_flag_q) begin
        shad_digits_q <= pend_digits_q;
        shad_en_q     <= pend_en_q;
        pend_flag_q   <= 1'b0;
      end
      if (load && !pend_flag_q) begin
        pend_digits_q <= digits_in;
        pend_en_q     <= digit_en;
        pend_flag_q   <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [MAX_DIGITS-1:0] DigitMask = MAX_DIGITS'((1 << NUM_DIGITS) - 1);
  logic [MAX_DIGITS-1:0] nonzero;

  // Enabled nonzero digits within the scanned range.
  always_comb begin
    nonzero = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      nonzero[i] = shad_en_q[i] && (shad_digits_q[4*i +: BCD_W] != '0);
    end
    nonzero = nonzero & DigitMask;
  end
`endif

  // Current slot decode: phase, nibble and whether the digit is lit.
  always_comb begin
    phase   = (32'(count) < BLANK_CYCLES) ? PhaseBlank : PhaseDrive;
    cur_nib = shad_digits_q[{idx_q, 2'b00} +: BCD_W];
    cur_lit = shad_en_q[idx_q] && (cur_nib <= BCD_MAX);
`ifdef LEADING_ZERO_BLANK_EN
    // Zero with no significant digit at or above this position is a leading zero.
    if ((cur_nib == '0) && (idx_q != 3'd0) && !(|(nonzero >> idx_q))) begin
      cur_lit = 1'b0;
    end
`endif
    anodes_d = ANODES_OFF;
    if ((phase == PhaseDrive) && cur_lit) begin
      anodes_d[idx_q] = 1'b0;
    end
  end

  // Registered outputs, one cycle behind the slot state.
  always_ff @(posedge clk) begin
    if (reset) begin
      anodes     <= ANODES_OFF;
      bcd_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      anodes     <= anodes_d;
      bcd_out    <= cur_nib;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 4-cycle slots, 1 blank cycle).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] digits_in = '0;
  logic [7:0]  digit_en = '0;
  logic        load = 1'b0;
  logic        ready;
  logic [3:0]  bcd_out;
  logic [7:0]  anodes;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .digit_en   (digit_en),
    .load       (load),
    .ready      (ready),
    .bcd_out    (bcd_out),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset is counted in edges; slot = (t/4)%4,
  // position in slot = t%4, a frame is 16 edges and ends when t%16 == 15.
  int unsigned m_e;
  logic [31:0] m_pend_d, m_shad_d;
  logic [7:0]  m_pend_en, m_shad_en;
  bit          m_pend_v;
  logic [7:0]  exp_anodes;
  logic [3:0]  exp_bcd;
  logic        exp_ready, exp_fd;
  logic [13:0] obs, expv;

  function automatic bit lit(int s);
    logic [3:0] n;
    bit any;
    n = m_shad_d[s*4 +: 4];
    if (!m_shad_en[s] || n > 4'd9) return 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (s != 0 && n == 4'd0) begin
      any = 1'b0;
      for (int j = s; j < 4; j++) begin
        if (m_shad_en[j] && m_shad_d[j*4 +: 4] != 4'd0) any = 1'b1;
      end
      if (!any) return 1'b0;
    end
`else
    any = 1'b0;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    int slot, pos;
    bit was_v;
    if (reset) begin
      m_e = 0; m_pend_v = 1'b0;
      m_pend_d = '0; m_pend_en = '0; m_shad_d = '0; m_shad_en = '0;
      exp_anodes = 8'hFF; exp_bcd = 4'h0; exp_ready = 1'b1; exp_fd = 1'b0;
    end else begin
      slot = int'((m_e / 4) % 4);
      pos  = int'(m_e % 4);
      exp_bcd    = m_shad_d[slot*4 +: 4];
      exp_anodes = (pos >= 1 && lit(slot)) ? ~(8'd1 << slot) : 8'hFF;
      exp_fd     = (m_e % 16 == 15);
      was_v = m_pend_v;
      if (exp_fd && m_pend_v) begin
        m_shad_d = m_pend_d; m_shad_en = m_pend_en; m_pend_v = 1'b0;
      end
      if (load && !was_v) begin
        m_pend_d = digits_in; m_pend_en = digit_en; m_pend_v = 1'b1;
      end
      exp_ready = !m_pend_v;
      m_e++;
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {anodes, bcd_out, ready, frame_done};
    n_cmp++;
    if (obs !== {8'hFF, 4'h0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL reset_held got %h want %h", obs, {8'hFF, 4'h0, 1'b1, 1'b0});
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      obs = {anodes, bcd_out, ready, frame_done};
      n_cmp++;
      if (obs !== {8'hFF, 4'h0, 1'b1, 1'b0}) begin
        n_bad++; $display("FAIL reset_idle c=%0d got %h want %h", c, obs, {8'hFF, 4'h0, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_load_basic();
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      obs = {anodes, bcd_out, ready, frame_done};
      expv = {exp_anodes, exp_bcd, exp_ready, exp_fd};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL load_basic c=%0d got %h want %h", c, obs, expv);
      end
      if (c == 1) begin
        n_cmp++;
        if (ready !== 1'b0) begin
          n_bad++; $display("FAIL load_ready_low got %b want 0", ready);
        end
      end
      load = (c == 0); digits_in = 32'h0000_1234; digit_en = 8'h0F;
    end
    load = 1'b0;
  endtask

  task automatic test_load_ignored();
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      obs = {anodes, bcd_out, ready, frame_done};
      expv = {exp_anodes, exp_bcd, exp_ready, exp_fd};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL load_ignored c=%0d got %h want %h", c, obs, expv);
      end
      load = (c == 0 || c == 2);
      digits_in = (c == 0) ? 32'h0000_1234 : 32'h0000_5678;
      digit_en = 8'h0F;
    end
    load = 1'b0;
  endtask

  task automatic test_dark();
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      obs = {anodes, bcd_out, ready, frame_done};
      expv = {exp_anodes, exp_bcd, exp_ready, exp_fd};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL dark c=%0d got %h want %h", c, obs, expv);
      end
      load = (c == 0 || c == 24);
      digits_in = (c == 0) ? 32'h0000_1234 : 32'h0000_12C4;
      digit_en = (c == 0) ? 8'h0A : 8'h0F;
    end
    load = 1'b0;
  endtask

  task automatic test_wrap_load();
    bit done = 1'b0;
    int at = -1;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      obs = {anodes, bcd_out, ready, frame_done};
      expv = {exp_anodes, exp_bcd, exp_ready, exp_fd};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL wrap_load c=%0d got %h want %h", c, obs, expv);
      end
      if (c == at) begin
        n_cmp++;
        if ({ready, frame_done} !== 2'b01) begin
          n_bad++; $display("FAIL wrap_load_edge got %b want 01", {ready, frame_done});
        end
      end
      load = 1'b0;
      if (!done && c >= 16 && exp_ready && (m_e % 16 == 15)) begin
        load = 1'b1; digits_in = 32'h0000_4321; digit_en = 8'h0F;
        done = 1'b1; at = c + 1;
      end
    end
    load = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++; $display("FAIL wrap_load_align got 0 want 1");
    end
  endtask

  task automatic test_lzb();
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      obs = {anodes, bcd_out, ready, frame_done};
      expv = {exp_anodes, exp_bcd, exp_ready, exp_fd};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL lzb c=%0d got %h want %h", c, obs, expv);
      end
      load = (c == 0 || c == 32);
      digits_in = (c == 0) ? 32'h0000_0070 : 32'h0000_0000;
      digit_en = 8'h0F;
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      obs = {anodes, bcd_out, ready, frame_done};
      expv = {exp_anodes, exp_bcd, exp_ready, exp_fd};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL random c=%0d got %h want %h", c, obs, expv);
      end
      load = ($urandom_range(0, 7) == 0);
      digits_in = $urandom();
      digit_en = 8'($urandom());
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      obs = {anodes, bcd_out, ready, frame_done};
      expv = {exp_anodes, exp_bcd, exp_ready, exp_fd};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL reset_mid_pre c=%0d got %h want %h", c, obs, expv);
      end
      load = (c == 0); digits_in = 32'h0000_9999; digit_en = 8'h0F;
      if (c >= 2 && (m_e % 4 == 2)) begin
        reset = 1'b1; hit = 1'b1;
      end
    end
    load = 1'b0;
    @(negedge clk);
    obs = {anodes, bcd_out, ready, frame_done};
    n_cmp++;
    if (obs !== {8'hFF, 4'h0, 1'b1, 1'b0} || !hit) begin
      n_bad++; $display("FAIL reset_mid got %h want %h", obs, {8'hFF, 4'h0, 1'b1, 1'b0});
    end
    reset = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      obs = {anodes, bcd_out, ready, frame_done};
      expv = {exp_anodes, exp_bcd, exp_ready, exp_fd};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL reset_mid_post c=%0d got %h want %h", c, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_load_ignored();
    test_dark();
    test_wrap_load();
    test_lzb();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
